// File: rtl/mod_settings_loader.sv
// Modulation settings loader: polls the controller-BRAM flag word and, on a 0->1 edge of the
// mod-set bit, reads 12 settings words into shadows and commits them atomically with UPDATE.
// Optional build macro MOD_SETTINGS_VALIDATE_EN rejects sets whose CYCLE or FREQ_DIV is zero.

module mod_settings_loader #(
  parameter int BRAM_LATENCY = 2
) (
  input  logic        CLK,
  input  logic        RST_N,
  output logic        BRAM_EN,
  output logic [7:0]  BRAM_ADDR,
  input  logic [15:0] BRAM_DOUT,
  output logic        REQ_RD_SEGMENT,
  output logic [31:0] CYCLE,
  output logic [31:0] FREQ_DIV,
  output logic [31:0] REP,
  output logic [7:0]  TRANSITION_MODE,
  output logic [63:0] TRANSITION_VALUE,
  output logic        UPDATE,
  output logic        BUSY
);
  localparam int         NUM_WORDS = 12;
  localparam logic [7:0] FLAG_ADDR = 8'h00;
  localparam logic [7:0] BASE_ADDR = 8'h22;
  localparam logic [3:0] LAST_IDX  = 4'(NUM_WORDS - 1);

  typedef enum logic [2:0] {
    POLL, POLL_WAIT, CHECK, LOAD, LOAD_WAIT, COMMIT
  } state_e;

  // Read tag travelling alongside the BRAM latency: flag poll or settings word index.
  typedef struct packed {
    logic       poll;
    logic [3:0] idx;
  } tag_t;

  typedef struct packed {
    logic        seg;
    logic [31:0] cycle;
    logic [31:0] freq_div;
    logic [31:0] rep;
    logic [7:0]  mode;
    logic [63:0] tval;
  } settings_t;

  state_e                       state_q, state_d;
  logic                         run_q, run_d;
  logic [3:0]                   ld_idx_q, ld_idx_d;
  logic [BRAM_LATENCY-1:0]      vld_pipe_q, vld_pipe_d;
  tag_t [BRAM_LATENCY-1:0]      tag_pipe_q, tag_pipe_d;
  logic [NUM_WORDS-1:0][15:0]   shadow_q, shadow_d;
  logic                         flag_q, flag_d;
  logic                         prev_q, prev_d;
  logic                         last_cap_q, last_cap_d;
  logic                         update_q, update_d;
  settings_t                    out_q, out_d;

  settings_t shadow_set;
  logic      cap_vld;
  tag_t      cap_tag;
  logic      issue;
  tag_t      issue_tag;
  logic      cfg_ok;
  logic      bram_en;
  logic [7:0] bram_addr;
  logic      unused_bits;

  assign cap_vld = vld_pipe_q[BRAM_LATENCY-1];
  assign cap_tag = tag_pipe_q[BRAM_LATENCY-1];

  always_comb begin
    shadow_set.seg      = shadow_q[0][0];
    shadow_set.cycle    = {shadow_q[2], shadow_q[1]};
    shadow_set.freq_div = {shadow_q[4], shadow_q[3]};
    shadow_set.rep      = {shadow_q[6], shadow_q[5]};
    shadow_set.mode     = shadow_q[7][7:0];
    shadow_set.tval     = {shadow_q[11], shadow_q[10], shadow_q[9], shadow_q[8]};
  end

  assign unused_bits = ^{shadow_q[0][15:1], shadow_q[7][15:8]};

`ifdef MOD_SETTINGS_VALIDATE_EN
  assign cfg_ok = (shadow_set.cycle != 32'd0) && (shadow_set.freq_div != 32'd0);
`else
  assign cfg_ok = 1'b1;
`endif

  always_comb begin
    state_d    = state_q;
    run_d      = 1'b1;
    ld_idx_d   = ld_idx_q;
    shadow_d   = shadow_q;
    flag_d     = flag_q;
    prev_d     = prev_q;
    last_cap_d = last_cap_q;
    out_d      = out_q;
    update_d   = 1'b0;
    bram_en    = 1'b0;
    bram_addr  = FLAG_ADDR;
    issue      = 1'b0;
    issue_tag  = '0;

    // Capture whatever read emerges from the BRAM this cycle.
    if (cap_vld) begin
      if (cap_tag.poll) begin
        flag_d = BRAM_DOUT[0];
      end else begin
        for (int w = 0; w < NUM_WORDS; w++) begin
          if (cap_tag.idx == 4'(w)) shadow_d[w] = BRAM_DOUT;
        end
        if (cap_tag.idx == LAST_IDX) last_cap_d = 1'b1;
      end
    end

    case (state_q)
      POLL: begin
        // Held idle for the first cycle out of reset.
        if (run_q) begin
          bram_en        = 1'b1;
          issue          = 1'b1;
          issue_tag.poll = 1'b1;
          state_d        = POLL_WAIT;
        end
      end
      POLL_WAIT: begin
        if (cap_vld && cap_tag.poll) state_d = CHECK;
      end
      CHECK: begin
        prev_d = flag_q;
        if (flag_q && !prev_q) begin
          state_d    = LOAD;
          ld_idx_d   = 4'd0;
          last_cap_d = 1'b0;
        end else begin
          state_d = POLL;
        end
      end
      LOAD: begin
        bram_en       = 1'b1;
        bram_addr     = BASE_ADDR + {4'h0, ld_idx_q};
        issue         = 1'b1;
        issue_tag.idx = ld_idx_q;
        if (ld_idx_q == LAST_IDX) begin
          ld_idx_d = 4'd0;
          state_d  = LOAD_WAIT;
        end else begin
          ld_idx_d = ld_idx_q + 4'd1;
        end
      end
      LOAD_WAIT: begin
        // Outputs load on the edge into COMMIT so they are valid alongside UPDATE.
        if (last_cap_q) begin
          if (cfg_ok) begin
            state_d  = COMMIT;
            out_d    = shadow_set;
            update_d = 1'b1;
          end else begin
            state_d = POLL;
          end
        end
      end
      COMMIT:  state_d = POLL;
      default: state_d = POLL;
    endcase

    vld_pipe_d    = '0;
    tag_pipe_d    = '0;
    vld_pipe_d[0] = issue;
    tag_pipe_d[0] = issue_tag;
    for (int k = 1; k < BRAM_LATENCY; k++) begin
      vld_pipe_d[k] = vld_pipe_q[k-1];
      tag_pipe_d[k] = tag_pipe_q[k-1];
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= POLL;
      run_q      <= 1'b0;
      ld_idx_q   <= '0;
      vld_pipe_q <= '0;
      tag_pipe_q <= '0;
      shadow_q   <= '0;
      flag_q     <= 1'b0;
      prev_q     <= 1'b0;
      last_cap_q <= 1'b0;
      update_q   <= 1'b0;
      out_q      <= '0;
    end else begin
      state_q    <= state_d;
      run_q      <= run_d;
      ld_idx_q   <= ld_idx_d;
      vld_pipe_q <= vld_pipe_d;
      tag_pipe_q <= tag_pipe_d;
      shadow_q   <= shadow_d;
      flag_q     <= flag_d;
      prev_q     <= prev_d;
      last_cap_q <= last_cap_d;
      update_q   <= update_d;
      out_q      <= out_d;
    end
  end

  assign BRAM_EN          = bram_en;
  assign BRAM_ADDR        = bram_addr;
  assign REQ_RD_SEGMENT   = out_q.seg;
  assign CYCLE            = out_q.cycle;
  assign FREQ_DIV         = out_q.freq_div;
  assign REP              = out_q.rep;
  assign TRANSITION_MODE  = out_q.mode;
  assign TRANSITION_VALUE = out_q.tval;
  assign UPDATE           = update_q;
  assign BUSY             = (state_q == LOAD) || (state_q == LOAD_WAIT) || (state_q == COMMIT);

endmodule

// File: tb/tb_mod_settings_loader.sv
// Directed bench for mod_settings_loader: three instances (BRAM_LATENCY 1, 2, 3) share one
// controller-BRAM image; each has its own latency-matched read pipeline.

module tb_mod_settings_loader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] mem [0:255];

  logic [2:0]        en_w, seg_w, upd_w, busy_w;
  logic [2:0][7:0]   addr_w, mode_w;
  logic [2:0][31:0]  cyc_w, fd_w, rep_w;
  logic [2:0][63:0]  tv_w;
  logic [15:0]       dout_w [3];

  localparam logic [11:0][15:0] SET_A = {16'hDEF0, 16'h9ABC, 16'h5678, 16'h1234, 16'h0001, 16'h0000,
                                         16'h0003, 16'h0000, 16'h0A00, 16'h0000, 16'h0FFF, 16'h0001};
  localparam logic [11:0][15:0] SET_B = {16'h4444, 16'h3333, 16'h2222, 16'h1111, 16'h0002, 16'h0000,
                                         16'h0000, 16'h0000, 16'h0002, 16'h0000, 16'h0010, 16'h0000};
  localparam logic [11:0][15:0] SET_C = {16'h8888, 16'h7777, 16'h6666, 16'h5555, 16'h0002, 16'h0000,
                                         16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0010, 16'h0000};
  localparam logic [168:0] EXP_A = {1'b1, 32'h0000_0FFF, 32'h0000_0A00, 32'd3, 8'h01, 64'hDEF0_9ABC_5678_1234};
  localparam logic [168:0] EXP_B = {1'b0, 32'h0000_0010, 32'h0000_0002, 32'd0, 8'h02, 64'h4444_3333_2222_1111};
  localparam logic [168:0] EXP_C = {1'b0, 32'h0000_0010, 32'h0000_0000, 32'd0, 8'h02, 64'h8888_7777_6666_5555};

  for (genvar g = 0; g < 3; g++) begin : lane
    logic [15:0] st [0:g];
    mod_settings_loader #(.BRAM_LATENCY(g + 1)) u_dut (
      .CLK(clk), .RST_N(rst_n), .BRAM_EN(en_w[g]), .BRAM_ADDR(addr_w[g]), .BRAM_DOUT(dout_w[g]),
      .REQ_RD_SEGMENT(seg_w[g]), .CYCLE(cyc_w[g]), .FREQ_DIV(fd_w[g]), .REP(rep_w[g]),
      .TRANSITION_MODE(mode_w[g]), .TRANSITION_VALUE(tv_w[g]), .UPDATE(upd_w[g]), .BUSY(busy_w[g])
    );
    // Output register holds the last read while BRAM_EN is low.
    always @(posedge clk) begin
      if (en_w[g]) st[0] <= mem[addr_w[g]];
      for (int k = 1; k <= g; k++) st[k] <= st[k-1];
    end
    assign dout_w[g] = st[g];
  end

  function automatic logic [168:0] outs(input int g);
    return {seg_w[g], cyc_w[g], fd_w[g], rep_w[g], mode_w[g], tv_w[g]};
  endfunction

  // Event monitor: first LOAD cycle, UPDATE count/latency, BUSY cycles, output changes w/o UPDATE.
  int first_load [3];
  int upd_cnt [3];
  int upd_lat [3];
  int busy_cnt [3];
  int en_busy [3];
  int chg_bad [3];
  logic [168:0] snap [3];
  logic rst_prev = 1'b0;
  always @(negedge clk) begin
    for (int m = 0; m < 3; m++) begin
      if (en_w[m] && addr_w[m] == 8'h22) first_load[m] <= cyc;
      if (upd_w[m]) begin
        upd_cnt[m] <= upd_cnt[m] + 1;
        upd_lat[m] <= cyc - first_load[m];
      end
      if (busy_w[m]) busy_cnt[m] <= busy_cnt[m] + 1;
      if (busy_w[m] && en_w[m]) en_busy[m] <= en_busy[m] + 1;
      if (outs(m) != snap[m] && !upd_w[m] && rst_n && rst_prev) chg_bad[m] <= chg_bad[m] + 1;
      snap[m] <= outs(m);
    end
    rst_prev <= rst_n;
  end

  task automatic set_words(input logic [11:0][15:0] w);
    for (int i = 0; i < 12; i++) mem[34 + i] = w[i];
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    for (int g = 0; g < 3; g++) begin
      checks++;
      if ({en_w[g], upd_w[g], busy_w[g], addr_w[g], outs(g)} !== '0) begin
        errors++;
        $display("FAIL reset_state lane%0d: en=%b upd=%b busy=%b addr=%h outs=%h, want all 0",
                 g, en_w[g], upd_w[g], busy_w[g], addr_w[g], outs(g));
      end
    end
  endtask

  task automatic test_idle_poll();
    int pulses, bad_addr, bad_gap, last;
    int u0 [3];
    for (int g = 0; g < 3; g++) u0[g] = upd_cnt[g];
    @(negedge clk); rst_n = 1'b1; #1;
    checks++;
    if (en_w !== 3'b000) begin errors++; $display("FAIL en_at_release: got %b, want 000", en_w); end
    @(negedge clk); #1;
    checks++;
    if (en_w !== 3'b111) begin errors++; $display("FAIL en_one_cycle_after_release: got %b, want 111", en_w); end
    pulses = 0; bad_addr = 0; bad_gap = 0; last = -1;
    for (int i = 0; i < 100; i++) begin
      if (i > 0) begin @(negedge clk); #1; end
      if (en_w[1]) begin
        pulses++;
        if (addr_w[1] !== 8'h00) bad_addr++;
        if (last >= 0 && i - last != 4) bad_gap++;
        last = i;
      end
    end
    checks++;
    if (pulses != 25) begin errors++; $display("FAIL idle_poll_pulses: got %0d, want 25", pulses); end
    checks++;
    if (bad_addr != 0) begin errors++; $display("FAIL idle_poll_addr: got %0d non-zero addresses, want 0", bad_addr); end
    checks++;
    if (bad_gap != 0) begin errors++; $display("FAIL idle_poll_period: got %0d gaps != 4, want 0", bad_gap); end
    for (int g = 0; g < 3; g++) begin
      checks++;
      if (upd_cnt[g] - u0[g] != 0) begin
        errors++; $display("FAIL idle_no_update lane%0d: got %0d updates, want 0", g, upd_cnt[g] - u0[g]);
      end
    end
  endtask

  task automatic test_load();
    int u0 [3], b0 [3], e0 [3], c0 [3];
    for (int g = 0; g < 3; g++) begin
      u0[g] = upd_cnt[g]; b0[g] = busy_cnt[g]; e0[g] = en_busy[g]; c0[g] = chg_bad[g];
    end
    @(negedge clk);
    set_words(SET_A);
    mem[0] = 16'h0001;
    repeat (40) @(negedge clk);
    #1;
    for (int g = 0; g < 3; g++) begin
      checks++;
      if (upd_cnt[g] - u0[g] != 1) begin
        errors++; $display("FAIL load_update_count lane%0d: got %0d, want 1", g, upd_cnt[g] - u0[g]);
      end
      checks++;
      if (upd_lat[g] != 14 + g) begin
        errors++; $display("FAIL load_update_latency lane%0d: got %0d, want %0d", g, upd_lat[g], 14 + g);
      end
      checks++;
      if (outs(g) !== EXP_A) begin
        errors++; $display("FAIL load_outputs lane%0d: got %h, want %h", g, outs(g), EXP_A);
      end
      checks++;
      if (busy_cnt[g] - b0[g] != 15 + g) begin
        errors++; $display("FAIL load_busy_cycles lane%0d: got %0d, want %0d", g, busy_cnt[g] - b0[g], 15 + g);
      end
      checks++;
      if (en_busy[g] - e0[g] != 12) begin
        errors++; $display("FAIL load_en_cycles lane%0d: got %0d, want 12", g, en_busy[g] - e0[g]);
      end
      checks++;
      if (chg_bad[g] - c0[g] != 0) begin
        errors++; $display("FAIL load_partial_visible lane%0d: got %0d changes, want 0", g, chg_bad[g] - c0[g]);
      end
    end
  endtask

  task automatic test_hold();
    int u0 [3];
    for (int g = 0; g < 3; g++) u0[g] = upd_cnt[g];
    repeat (200) @(negedge clk);
    #1;
    for (int g = 0; g < 3; g++) begin
      checks++;
      if (upd_cnt[g] - u0[g] != 0) begin
        errors++; $display("FAIL hold_no_retrigger lane%0d: got %0d updates, want 0", g, upd_cnt[g] - u0[g]);
      end
      checks++;
      if (outs(g) !== EXP_A) begin
        errors++; $display("FAIL hold_outputs lane%0d: got %h, want %h", g, outs(g), EXP_A);
      end
    end
  endtask

  task automatic test_reset_mid_load();
    int u0 [3];
    bit found;
    mem[0] = 16'h0000;
    repeat (20) @(negedge clk);
    for (int g = 0; g < 3; g++) u0[g] = upd_cnt[g];
    set_words(SET_B);
    mem[0] = 16'h0001;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk); #1;
      if (en_w[1] && addr_w[1] == 8'h22) found = 1'b1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL mid_load_start_seen: got no LOAD within 40 cycles, want one"); end
    repeat (5) @(negedge clk);
    #1;
    checks++;
    if (!(en_w[1] && addr_w[1] == 8'h27)) begin
      errors++; $display("FAIL mid_load_sixth_addr: got en=%b addr=%h, want en=1 addr=27", en_w[1], addr_w[1]);
    end
    rst_n = 1'b0;
    mem[0] = 16'h0000;
    #1;
    for (int g = 0; g < 3; g++) begin
      checks++;
      if ({en_w[g], upd_w[g], busy_w[g], outs(g)} !== '0) begin
        errors++; $display("FAIL mid_load_reset_state lane%0d: en=%b upd=%b busy=%b outs=%h, want all 0",
                           g, en_w[g], upd_w[g], busy_w[g], outs(g));
      end
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    #1;
    for (int g = 0; g < 3; g++) begin
      checks++;
      if (upd_cnt[g] - u0[g] != 0 || outs(g) !== '0) begin
        errors++; $display("FAIL mid_load_abandoned lane%0d: got %0d updates outs=%h, want 0 updates outs 0",
                           g, upd_cnt[g] - u0[g], outs(g));
      end
    end
    @(negedge clk);
    mem[0] = 16'h0001;
    repeat (40) @(negedge clk);
    #1;
    for (int g = 0; g < 3; g++) begin
      checks++;
      if (upd_cnt[g] - u0[g] != 1) begin
        errors++; $display("FAIL reload_update_count lane%0d: got %0d, want 1", g, upd_cnt[g] - u0[g]);
      end
      checks++;
      if (upd_lat[g] != 14 + g) begin
        errors++; $display("FAIL reload_update_latency lane%0d: got %0d, want %0d", g, upd_lat[g], 14 + g);
      end
      checks++;
      if (outs(g) !== EXP_B) begin
        errors++; $display("FAIL reload_outputs lane%0d: got %h, want %h", g, outs(g), EXP_B);
      end
    end
  endtask

  task automatic test_validate();
    int u0 [3];
    int exp_upd;
    logic [168:0] exp_out;
`ifdef MOD_SETTINGS_VALIDATE_EN
    exp_upd = 0; exp_out = EXP_B;
`else
    exp_upd = 1; exp_out = EXP_C;
`endif
    mem[0] = 16'h0000;
    repeat (20) @(negedge clk);
    for (int g = 0; g < 3; g++) u0[g] = upd_cnt[g];
    set_words(SET_C);
    mem[0] = 16'h0001;
    repeat (40) @(negedge clk);
    #1;
    for (int g = 0; g < 3; g++) begin
      checks++;
      if (upd_cnt[g] - u0[g] != exp_upd) begin
        errors++; $display("FAIL zero_fdiv_update lane%0d: got %0d, want %0d", g, upd_cnt[g] - u0[g], exp_upd);
      end
      checks++;
      if (outs(g) !== exp_out) begin
        errors++; $display("FAIL zero_fdiv_outputs lane%0d: got %h, want %h", g, outs(g), exp_out);
      end
    end
    mem[0] = 16'h0000;
    repeat (20) @(negedge clk);
    for (int g = 0; g < 3; g++) u0[g] = upd_cnt[g];
    set_words(SET_A);
    mem[0] = 16'h0001;
    repeat (40) @(negedge clk);
    #1;
    for (int g = 0; g < 3; g++) begin
      checks++;
      if (upd_cnt[g] - u0[g] != 1) begin
        errors++; $display("FAIL valid_after_reject_update lane%0d: got %0d, want 1", g, upd_cnt[g] - u0[g]);
      end
      checks++;
      if (outs(g) !== EXP_A) begin
        errors++; $display("FAIL valid_after_reject_outputs lane%0d: got %h, want %h", g, outs(g), EXP_A);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    test_idle_poll();
    test_load();
    test_hold();
    test_reset_mid_load();
    test_validate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
